// File: rtl/sound_cmd_player_if.sv
// rtl/sound_cmd_player_if.sv - command/mute in, piezo drive and status out
interface sound_cmd_player_if;
  logic [1:0] i_Sound_Cmd;
  logic       i_Mute;
  logic       o_Piezo;
  logic       o_Busy;
  logic [1:0] o_Playing_Cmd;

  modport master (
    output i_Sound_Cmd, i_Mute,
    input  o_Piezo, o_Busy, o_Playing_Cmd
  );

  modport slave (
    input  i_Sound_Cmd, i_Mute,
    output o_Piezo, o_Busy, o_Playing_Cmd
  );
endinterface

// File: rtl/sound_cmd_player.sv
// rtl/sound_cmd_player.sv - turns one-cycle sound commands into timed piezo tone sequences
module sound_cmd_player #(
  parameter int unsigned NOTE_CYC     = 4_000_000,
  parameter int unsigned HP_PERFECT_A = 23_878,
  parameter int unsigned HP_PERFECT_B = 18_953,
  parameter int unsigned HP_GOOD      = 31_888,
  parameter int unsigned HP_MISS      = 125_000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  sound_cmd_player_if.slave bus
);

  typedef enum logic [1:0] {IDLE, NOTE1, NOTE2} state_t;

  localparam logic [1:0]  CMD_PERFECT = 2'd1;
  localparam logic [1:0]  CMD_MISS    = 2'd3;
  localparam logic [31:0] LEN_NOTE    = 32'(NOTE_CYC);
  localparam logic [31:0] LEN_MISS    = 32'(2 * NOTE_CYC);

  state_t      state, state_nxt;
  logic [1:0]  cmd_q, cmd_nxt;
  logic [19:0] tone_cnt, tone_nxt;
  logic [31:0] dur_cnt, dur_nxt;
  logic        square, sq_nxt;
  logic        piezo_q, piezo_nxt;
  logic        accept, note_end;
  logic [19:0] hp_cur;
  logic [31:0] len_cur;

  // miss outranks perfect, perfect outranks good
  function automatic logic [1:0] prio(input logic [1:0] c);
    case (c)
      2'd3:    prio = 2'd3;
      2'd1:    prio = 2'd2;
      2'd2:    prio = 2'd1;
      default: prio = 2'd0;
    endcase
  endfunction

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= IDLE;
      cmd_q    <= 2'd0;
      tone_cnt <= '0;
      dur_cnt  <= '0;
      square   <= 1'b0;
      piezo_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cmd_q    <= cmd_nxt;
      tone_cnt <= tone_nxt;
      dur_cnt  <= dur_nxt;
      square   <= sq_nxt;
      piezo_q  <= piezo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    len_cur   = (cmd_q == CMD_MISS) ? LEN_MISS : LEN_NOTE;
    accept    = (bus.i_Sound_Cmd != 2'd0) &&
                ((state == IDLE) || (prio(bus.i_Sound_Cmd) >= prio(cmd_q)));
    note_end  = (state != IDLE) && (dur_cnt == len_cur - 32'd1);
    if (accept) begin
      state_nxt = NOTE1;
      cmd_nxt   = bus.i_Sound_Cmd;
    end else if (note_end) begin
      if (state == NOTE1 && cmd_q == CMD_PERFECT) begin
        state_nxt = NOTE2;
      end else begin
        state_nxt = IDLE;
        cmd_nxt   = 2'd0;
      end
    end
  end

  always_comb begin
    tone_nxt = '0;
    dur_nxt  = '0;
    sq_nxt   = 1'b0;
    case (state)
      NOTE2: hp_cur = 20'(HP_PERFECT_B);
      NOTE1: begin
        case (cmd_q)
          2'd1:    hp_cur = 20'(HP_PERFECT_A);
          2'd3:    hp_cur = 20'(HP_MISS);
          default: hp_cur = 20'(HP_GOOD);
        endcase
      end
      default: hp_cur = 20'(HP_GOOD);
    endcase
    // note boundaries and (re)starts clear everything, swallowing any toggle due then
    if (!accept && !note_end && state != IDLE) begin
      dur_nxt = dur_cnt + 32'd1;
      if (tone_cnt == hp_cur - 20'd1) begin
        tone_nxt = '0;
        sq_nxt   = ~square;
      end else begin
        tone_nxt = tone_cnt + 20'd1;
        sq_nxt   = square;
      end
    end
    piezo_nxt = sq_nxt & ~bus.i_Mute;
  end

  assign bus.o_Piezo       = piezo_q;
  assign bus.o_Busy        = (state != IDLE);
  assign bus.o_Playing_Cmd = cmd_q;

endmodule

// File: tb/tb_sound_cmd_player.sv
// tb/tb_sound_cmd_player.sv - scoreboard bench for sound_cmd_player
module tb_sound_cmd_player;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;
  always #5 i_Clk = ~i_Clk;

  sound_cmd_player_if bus ();

  sound_cmd_player #(
    .NOTE_CYC(100), .HP_PERFECT_A(5), .HP_PERFECT_B(4), .HP_GOOD(7), .HP_MISS(20)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .bus(bus)
  );

  typedef struct {
    string      tag;
    int         cyc;
    logic       busy;
    logic [1:0] cmd;
    logic       pz;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  int         ev_cyc[$];
  logic [1:0] ev_cmd[$];
  bit         ev_rst[$];
  int         seg_s[$], seg_e[$], seg_hp[$];
  logic [1:0] seg_cmd[$];
  bit         mute_on;

  task automatic clear_test();
    ev_cyc.delete(); ev_cmd.delete(); ev_rst.delete();
    seg_s.delete(); seg_e.delete(); seg_hp.delete(); seg_cmd.delete();
    mute_on = 1'b0;
  endtask

  task automatic add_ev(input int c, input logic [1:0] cmd, input bit rst);
    ev_cyc.push_back(c); ev_cmd.push_back(cmd); ev_rst.push_back(rst);
  endtask

  task automatic add_seg(input int s, input int e, input int hp, input logic [1:0] cmd);
    seg_s.push_back(s); seg_e.push_back(e); seg_hp.push_back(hp); seg_cmd.push_back(cmd);
  endtask

  // a note entered at cycle s with half-period hp is high during odd multiples of hp after s
  function automatic exp_t expect_at(input string tag, input int k);
    exp_t e;
    e.tag = tag; e.cyc = k; e.busy = 1'b0; e.cmd = 2'd0; e.pz = 1'b0;
    for (int i = 0; i < seg_s.size(); i++) begin
      if (k >= seg_s[i] && k <= seg_e[i]) begin
        e.busy = 1'b1;
        e.cmd  = seg_cmd[i];
        e.pz   = (((k - seg_s[i]) / seg_hp[i]) % 2) == 1;
      end
    end
    if (mute_on) e.pz = 1'b0;
    return e;
  endfunction

  task automatic run_test(input string tag, input int ncyc);
    exp_t r;
    i_Rst = 1'b1;
    bus.i_Sound_Cmd = 2'd0;
    bus.i_Mute = mute_on;
    @(posedge i_Clk); #1;
    r.tag = {tag, "_reset"}; r.cyc = -1; r.busy = 1'b0; r.cmd = 2'd0; r.pz = 1'b0;
    exp_q.push_back(r);
    for (int k = 0; k <= ncyc; k++) begin
      @(posedge i_Clk); #1;
      i_Rst = 1'b0;
      bus.i_Sound_Cmd = 2'd0;
      for (int j = 0; j < ev_cyc.size(); j++) begin
        if (ev_cyc[j] == k) begin
          bus.i_Sound_Cmd = ev_cmd[j];
          i_Rst = ev_rst[j];
        end
      end
      exp_q.push_back(expect_at(tag, k));
    end
    @(posedge i_Clk); #1;
    bus.i_Sound_Cmd = 2'd0;
  endtask

  always @(negedge i_Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (bus.o_Busy !== e.busy) begin
        bad++;
        $display("FAIL %s busy cyc=%0d got=%b want=%b", e.tag, e.cyc, bus.o_Busy, e.busy);
      end
      total++;
      if (bus.o_Playing_Cmd !== e.cmd) begin
        bad++;
        $display("FAIL %s playing_cmd cyc=%0d got=%0d want=%0d", e.tag, e.cyc, bus.o_Playing_Cmd, e.cmd);
      end
      total++;
      if (bus.o_Piezo !== e.pz) begin
        bad++;
        $display("FAIL %s piezo cyc=%0d got=%b want=%b", e.tag, e.cyc, bus.o_Piezo, e.pz);
      end
    end
  end

  initial begin
    bus.i_Sound_Cmd = 2'd0;
    bus.i_Mute = 1'b0;

    clear_test();
    add_ev(0, 2'd2, 1'b0);
    add_seg(1, 100, 7, 2'd2);
    run_test("good", 110);

    clear_test();
    add_ev(0, 2'd1, 1'b0);
    add_seg(1, 100, 5, 2'd1);
    add_seg(101, 200, 4, 2'd1);
    run_test("perfect", 210);

    clear_test();
    add_ev(0, 2'd2, 1'b0);
    add_ev(30, 2'd3, 1'b0);
    add_ev(50, 2'd2, 1'b0);
    add_seg(1, 30, 7, 2'd2);
    add_seg(31, 230, 20, 2'd3);
    run_test("preempt", 240);

    clear_test();
    add_ev(0, 2'd1, 1'b0);
    add_ev(150, 2'd1, 1'b0);
    add_seg(1, 100, 5, 2'd1);
    add_seg(101, 150, 4, 2'd1);
    add_seg(151, 250, 5, 2'd1);
    add_seg(251, 350, 4, 2'd1);
    run_test("restart", 360);

    clear_test();
    add_ev(0, 2'd3, 1'b0);
    add_ev(40, 2'd2, 1'b1);
    add_ev(60, 2'd2, 1'b0);
    add_seg(1, 40, 20, 2'd3);
    add_seg(61, 160, 7, 2'd2);
    run_test("midreset", 170);

    clear_test();
    mute_on = 1'b1;
    add_ev(0, 2'd3, 1'b0);
    add_seg(1, 200, 20, 2'd3);
    run_test("mute", 210);

    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge i_Clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
